// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 memory arbiter: FSM state, access owner and R_W encoding.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Request/response and SRAM bus of the LC-3 memory arbiter.
// slave = arbiter side, master = CPU/debug/SRAM environment side.
interface lc3_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_MIO_EN;
    logic              i_R_W;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic [DATA_W-1:0] o_cpu_rdata;
    logic              o_Ready_Bit;

    logic              i_dbg_req;
    logic              i_dbg_we;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [DATA_W-1:0] i_dbg_wdata;
    logic              o_dbg_gnt;
    logic              o_dbg_valid;
    logic [DATA_W-1:0] o_dbg_rdata;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_busy;

    modport slave (
        input  i_MIO_EN, i_R_W, i_cpu_addr, i_cpu_wdata,
        output o_cpu_rdata, o_Ready_Bit,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        output o_dbg_gnt, o_dbg_valid, o_dbg_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_busy
    );

    modport master (
        output i_MIO_EN, i_R_W, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_rdata, o_Ready_Bit,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        input  o_dbg_gnt, o_dbg_valid, o_dbg_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_busy
    );
endinterface

// File: rtl/lc3_mem_wait_timer.sv
// SRAM wait-state timer: loaded at grant, counts down through ACCESS, flags the last cycle.
module lc3_mem_wait_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_Reset,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("lc3_mem_wait_timer: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    // Saturates at zero so a stray enable after the access cannot wrap.
    always_ff @(posedge i_clk) begin
        if (i_Reset)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(WAIT_CYCLES);
        else if (en && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign last = (cnt == CNT_W'(1));
endmodule

// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory sequencer sharing one SRAM port between the CPU datapath and a debug/loader port.
// Optional LC3_MEMARB_RR_EN: alternate on simultaneous requests instead of fixed CPU priority.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input logic              i_clk,
    input logic              i_Reset,
    lc3_mem_arbiter_if.slave bus
);
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    owner_t            owner;
    req_t              req_q, cpu_in, dbg_in;
    logic              cpu_req, dbg_req, grant, grant_cpu;
    logic              cpu_armed, dbg_first;
    logic              timer_last, last_acc;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

    // A Ready-completed CPU access disarms the CPU until microcode drops MIO_EN.
    assign cpu_req = bus.i_MIO_EN & cpu_armed;
    assign dbg_req = bus.i_dbg_req;
    assign grant   = (state == ST_IDLE) & (cpu_req | dbg_req);

`ifdef LC3_MEMARB_RR_EN
    owner_t last_grant;

    always_ff @(posedge i_clk) begin
        if (i_Reset)
            last_grant <= OWN_DBG;
        else if (grant)
            last_grant <= grant_cpu ? OWN_CPU : OWN_DBG;
    end

    assign grant_cpu = cpu_req & (~dbg_req | (last_grant == OWN_DBG));
`else
    assign grant_cpu = cpu_req;
`endif

    always_comb begin
        cpu_in       = '0;
        cpu_in.we    = bus.i_R_W;
        cpu_in.addr  = bus.i_cpu_addr;
        cpu_in.wdata = bus.i_cpu_wdata;
        dbg_in       = '0;
        dbg_in.we    = bus.i_dbg_we;
        dbg_in.addr  = bus.i_dbg_addr;
        dbg_in.wdata = bus.i_dbg_wdata;
    end

    lc3_mem_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .i_clk   (i_clk),
        .i_Reset (i_Reset),
        .load    (grant),
        .en      (state == ST_ACCESS),
        .last    (timer_last)
    );

    assign last_acc = timer_last & (state == ST_ACCESS);

    always_ff @(posedge i_clk) begin
        if (i_Reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (grant) state_nxt = ST_ACCESS;
            ST_ACCESS: if (last_acc) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_mem_en    = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_Ready_Bit = 1'b0;
        bus.o_dbg_gnt   = 1'b0;
        bus.o_dbg_valid = 1'b0;
        bus.o_mem_addr  = req_q.addr;
        bus.o_mem_wdata = req_q.wdata;
        bus.o_cpu_rdata = cpu_rdata_q;
        bus.o_dbg_rdata = dbg_rdata_q;
        bus.o_busy      = (state != ST_IDLE);
        unique case (state)
            ST_ACCESS: begin
                bus.o_mem_en  = 1'b1;
                bus.o_mem_we  = (req_q.we == RW_WRITE);
                bus.o_dbg_gnt = dbg_first;
            end
            ST_DONE: begin
                bus.o_Ready_Bit = (owner == OWN_CPU);
                bus.o_dbg_valid = (owner == OWN_DBG);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            req_q       <= '0;
            owner       <= OWN_CPU;
            dbg_first   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_armed   <= 1'b1;
        end else begin
            dbg_first <= grant & ~grant_cpu;
            if (grant) begin
                owner <= grant_cpu ? OWN_CPU : OWN_DBG;
                req_q <= grant_cpu ? cpu_in : dbg_in;
            end
            // Read data is taken at the end of the final wait state and held until the next read.
            if (last_acc && req_q.we == RW_READ) begin
                if (owner == OWN_CPU)
                    cpu_rdata_q <= bus.i_mem_rdata;
                else
                    dbg_rdata_q <= bus.i_mem_rdata;
            end
            if (state == ST_DONE && owner == OWN_CPU)
                cpu_armed <= 1'b0;
            else if (!bus.i_MIO_EN)
                cpu_armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level schedule/memory model. Honors LC3_MEMARB_RR_EN for arbitration expectations.
module tb_lc3_mem_arbiter;
    localparam int W = 2;
`ifdef LC3_MEMARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_Reset(rst), .bus(bus));
    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .i_clk(clk), .i_Reset(rst), .bus(bus1));

    // SRAM: unwritten words read as addr ^ x2234, so mem[x3000] = x1234.
    logic [15:0] sram    [0:65535];
    bit          sram_wr [0:65535];
    assign bus.i_mem_rdata = sram_wr[bus.o_mem_addr] ? sram[bus.o_mem_addr]
                                                     : bus.o_mem_addr ^ 16'h2234;
    always @(posedge clk) begin
        if (bus.o_mem_en && bus.o_mem_we) begin
            sram[bus.o_mem_addr]    <= bus.o_mem_wdata;
            sram_wr[bus.o_mem_addr] <= 1'b1;
        end
    end
    assign bus1.i_mem_rdata = bus1.o_mem_addr ^ 16'hC3C3;

    // Reference memory contents, updated when an access is expected to complete.
    logic [15:0] m_val [0:65535];
    bit          m_wr  [0:65535];
    bit          m_last_dbg;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        return m_wr[a] ? m_val[a] : (a ^ 16'h2234);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_MIO_EN = 0;  bus.i_R_W = 0;  bus.i_cpu_addr = 0;  bus.i_cpu_wdata = 0;
        bus.i_dbg_req = 0; bus.i_dbg_we = 0; bus.i_dbg_addr = 0; bus.i_dbg_wdata = 0;
        bus1.i_MIO_EN = 0; bus1.i_R_W = 0; bus1.i_cpu_addr = 0; bus1.i_cpu_wdata = 0;
        bus1.i_dbg_req = 0; bus1.i_dbg_we = 0; bus1.i_dbg_addr = 0; bus1.i_dbg_wdata = 0;
    endtask

    task automatic test_reset();
        logic [5:0]  obs;
        logic [63:0] dat;
        rst = 1;
        drive_idle();
        tick(); tick();
        obs = {bus.o_mem_en, bus.o_mem_we, bus.o_Ready_Bit, bus.o_dbg_gnt, bus.o_dbg_valid, bus.o_busy};
        n_chk++;
        if (obs !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got=%b want=000000", obs);
        end
        dat = {bus.o_cpu_rdata, bus.o_dbg_rdata, bus.o_mem_addr, bus.o_mem_wdata};
        n_chk++;
        if (dat !== 64'h0) begin
            n_fail++; $display("FAIL reset_data got=%h want=0", dat);
        end
        rst = 0;
        m_last_dbg = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        logic [3:0] obs, exp;
        bus.i_MIO_EN = 1; bus.i_R_W = 0; bus.i_cpu_addr = 16'h3000; bus.i_cpu_wdata = 16'h5555;
        m_last_dbg = 1'b0;
        for (int c = 1; c <= W + 5; c++) begin
            tick();
            obs = {bus.o_mem_en, bus.o_mem_we, bus.o_Ready_Bit, bus.o_busy};
            exp = {c <= W, 1'b0, c == W + 1, c <= W + 1};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL cpu_read_ctrl cyc=%0d got=%b want=%b", c, obs, exp);
            end
            if (c <= W) begin
                n_chk++;
                if (bus.o_mem_addr !== 16'h3000) begin
                    n_fail++; $display("FAIL cpu_read_addr cyc=%0d got=%h want=3000", c, bus.o_mem_addr);
                end
            end
            if (c == W + 1) begin
                n_chk++;
                if (bus.o_cpu_rdata !== 16'h1234) begin
                    n_fail++; $display("FAIL cpu_read_data got=%h want=1234", bus.o_cpu_rdata);
                end
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_cpu_write();
        logic [3:0] obs, exp;
        bus.i_MIO_EN = 1; bus.i_R_W = 1; bus.i_cpu_addr = 16'h3001; bus.i_cpu_wdata = 16'hBEEF;
        m_last_dbg = 1'b0;
        for (int c = 1; c <= W + 3; c++) begin
            tick();
            obs = {bus.o_mem_en, bus.o_mem_we, bus.o_Ready_Bit, bus.o_busy};
            exp = {c <= W, c <= W, c == W + 1, c <= W + 1};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL cpu_write_ctrl cyc=%0d got=%b want=%b", c, obs, exp);
            end
            if (c <= W) begin
                n_chk++;
                if ({bus.o_mem_addr, bus.o_mem_wdata} !== 32'h3001BEEF) begin
                    n_fail++; $display("FAIL cpu_write_bus cyc=%0d got=%h%h want=3001beef", c,
                                       bus.o_mem_addr, bus.o_mem_wdata);
                end
            end
            if (bus.o_Ready_Bit) bus.i_MIO_EN = 0;
        end
        n_chk++;
        if (bus.o_cpu_rdata !== 16'h1234) begin
            n_fail++; $display("FAIL cpu_write_rdata_hold got=%h want=1234", bus.o_cpu_rdata);
        end
        n_chk++;
        if (!sram_wr[16'h3001] || sram[16'h3001] !== 16'hBEEF) begin
            n_fail++; $display("FAIL cpu_write_mem got=%h want=beef", sram[16'h3001]);
        end
        m_wr[16'h3001] = 1'b1; m_val[16'h3001] = 16'hBEEF;
        drive_idle();
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] obs, exp;
        bit dbg_first;
        dbg_first = RR_EN && !m_last_dbg;
        bus.i_MIO_EN = 1; bus.i_R_W = 0; bus.i_cpu_addr = 16'h0041;
        bus.i_dbg_req = 1; bus.i_dbg_we = 0; bus.i_dbg_addr = 16'h0040;
        m_last_dbg = !dbg_first;
        for (int c = 1; c <= 2 * W + 5; c++) begin
            tick();
            obs = {bus.o_mem_en, bus.o_dbg_gnt, bus.o_Ready_Bit, bus.o_dbg_valid};
            exp = {(c >= 1 && c <= W) || (c >= W + 3 && c <= 2 * W + 2),
                   dbg_first ? c == 1 : c == W + 3,
                   dbg_first ? c == 2 * W + 3 : c == W + 1,
                   dbg_first ? c == W + 1 : c == 2 * W + 3};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL contention_ctrl cyc=%0d got=%b want=%b", c, obs, exp);
            end
            if (bus.o_Ready_Bit) begin
                n_chk++;
                if (bus.o_cpu_rdata !== m_rd(16'h0041)) begin
                    n_fail++; $display("FAIL contention_cpu_data got=%h want=%h", bus.o_cpu_rdata, m_rd(16'h0041));
                end
                bus.i_MIO_EN = 0;
            end
            if (bus.o_dbg_valid) begin
                n_chk++;
                if (bus.o_dbg_rdata !== m_rd(16'h0040)) begin
                    n_fail++; $display("FAIL contention_dbg_data got=%h want=%h", bus.o_dbg_rdata, m_rd(16'h0040));
                end
            end
            if (bus.o_dbg_gnt) bus.i_dbg_req = 0;
        end
        drive_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, exp;
        int gnts = 0;
        bus.i_dbg_req = 1; bus.i_dbg_we = 0; bus.i_dbg_addr = 16'h0000;
        m_last_dbg = 1'b1;
        for (int c = 1; c <= 2 * W + 5; c++) begin
            tick();
            obs = {bus.o_mem_en, bus.o_dbg_gnt, bus.o_dbg_valid, bus.o_busy};
            exp = {(c >= 1 && c <= W) || (c >= W + 3 && c <= 2 * W + 2),
                   c == 1 || c == W + 3,
                   c == W + 1 || c == 2 * W + 3,
                   c <= 2 * W + 3 && c != W + 2};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL b2b_ctrl cyc=%0d got=%b want=%b", c, obs, exp);
            end
            if (bus.o_mem_en) begin
                n_chk++;
                if (bus.o_mem_addr !== ((c <= W) ? 16'h0000 : 16'h0001)) begin
                    n_fail++; $display("FAIL b2b_addr cyc=%0d got=%h want=%h", c, bus.o_mem_addr,
                                       (c <= W) ? 16'h0000 : 16'h0001);
                end
            end
            if (bus.o_dbg_valid) begin
                n_chk++;
                if (bus.o_dbg_rdata !== m_rd((c <= W + 1) ? 16'h0000 : 16'h0001)) begin
                    n_fail++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", c, bus.o_dbg_rdata,
                                       m_rd((c <= W + 1) ? 16'h0000 : 16'h0001));
                end
            end
            if (bus.o_dbg_gnt) begin
                gnts++;
                if (gnts == 1) bus.i_dbg_addr = 16'h0001;
                else bus.i_dbg_req = 0;
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        bus.i_MIO_EN = 1; bus.i_R_W = 0; bus.i_cpu_addr = 16'h3001;
        tick(); tick();
        n_chk++;
        if (bus.o_mem_en !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre_en got=%b want=1", bus.o_mem_en);
        end
        rst = 1;
        tick();
        obs = {bus.o_mem_en, bus.o_Ready_Bit, bus.o_dbg_valid, bus.o_busy};
        n_chk++;
        if (obs !== 4'b0 || bus.o_cpu_rdata !== 16'h0) begin
            n_fail++; $display("FAIL rstmid_abort got=%b/%h want=0000/0000", obs, bus.o_cpu_rdata);
        end
        rst = 0;
        m_last_dbg = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            tick();
            obs = {bus.o_mem_en, bus.o_mem_we, bus.o_Ready_Bit, bus.o_busy};
            exp = {c <= W, 1'b0, c == W + 1, c <= W + 1};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rstmid_retry cyc=%0d got=%b want=%b", c, obs, exp);
            end
            if (bus.o_Ready_Bit) begin
                n_chk++;
                if (bus.o_cpu_rdata !== 16'hBEEF) begin
                    n_fail++; $display("FAIL rstmid_data got=%h want=beef", bus.o_cpu_rdata);
                end
                bus.i_MIO_EN = 0;
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_wait1();
        logic [1:0] obs, exp;
        bus1.i_MIO_EN = 1; bus1.i_R_W = 0; bus1.i_cpu_addr = 16'h0123;
        for (int c = 1; c <= 4; c++) begin
            tick();
            obs = {bus1.o_mem_en, bus1.o_Ready_Bit};
            exp = {c == 1, c == 2};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL wait1_ctrl cyc=%0d got=%b want=%b", c, obs, exp);
            end
            if (bus1.o_Ready_Bit) begin
                n_chk++;
                if (bus1.o_cpu_rdata !== (16'h0123 ^ 16'hC3C3)) begin
                    n_fail++; $display("FAIL wait1_data got=%h want=%h", bus1.o_cpu_rdata, 16'h0123 ^ 16'hC3C3);
                end
                bus1.i_MIO_EN = 0;
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int          kind, n, done, lag, cur, fin, s;
            bit          dbg_first;
            bit          own [2];
            bit          twe [2];
            logic [15:0] ta [2];
            logic [15:0] tw [2];
            logic [3:0]  obs, exp;
            kind = $urandom_range(0, 2);
            bus.i_R_W = 1'($urandom_range(0, 1));
            bus.i_cpu_addr = 16'h0100 + 16'($urandom_range(0, 7));
            bus.i_cpu_wdata = 16'($urandom);
            bus.i_dbg_we = 1'($urandom_range(0, 1));
            bus.i_dbg_addr = 16'h0100 + 16'($urandom_range(0, 7));
            bus.i_dbg_wdata = 16'($urandom);
            dbg_first = (kind == 1) || (kind == 2 && RR_EN && !m_last_dbg);
            n = (kind == 2) ? 2 : 1;
            own[0] = dbg_first;
            own[1] = !dbg_first;
            for (int k = 0; k < 2; k++) begin
                twe[k] = own[k] ? bus.i_dbg_we : bus.i_R_W;
                ta[k]  = own[k] ? bus.i_dbg_addr : bus.i_cpu_addr;
                tw[k]  = own[k] ? bus.i_dbg_wdata : bus.i_cpu_wdata;
            end
            m_last_dbg = own[n-1];
            bus.i_MIO_EN = (kind != 1);
            bus.i_dbg_req = (kind != 0);
            done = 0; lag = -1;
            for (int c = 1; c <= 2 * W + 8; c++) begin
                tick();
                exp = '0; cur = 0; fin = -1;
                for (int k = 0; k < n; k++) begin
                    s = k * (W + 2);
                    if (c > s && c <= s + W) begin exp[3] = 1'b1; cur = k; end
                    if (c == s + 1 && own[k]) exp[2] = 1'b1;
                    if (c == s + W + 1) begin
                        if (own[k]) exp[0] = 1'b1; else exp[1] = 1'b1;
                        fin = k;
                    end
                end
                obs = {bus.o_mem_en, bus.o_dbg_gnt, bus.o_Ready_Bit, bus.o_dbg_valid};
                n_chk++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL rand_ctrl it=%0d kind=%0d cyc=%0d got=%b want=%b", it, kind, c, obs, exp);
                end
                if (exp[3] && bus.o_mem_en) begin
                    n_chk++;
                    if ({bus.o_mem_we, bus.o_mem_addr} !== {twe[cur], ta[cur]} ||
                        (twe[cur] && bus.o_mem_wdata !== tw[cur])) begin
                        n_fail++; $display("FAIL rand_bus it=%0d cyc=%0d got=%b/%h/%h want=%b/%h/%h", it, c,
                                           bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, twe[cur], ta[cur], tw[cur]);
                    end
                end
                if (fin >= 0 && obs === exp) begin
                    done++;
                    if (twe[fin]) begin
                        m_wr[ta[fin]] = 1'b1; m_val[ta[fin]] = tw[fin];
                    end else begin
                        n_chk++;
                        if ((own[fin] ? bus.o_dbg_rdata : bus.o_cpu_rdata) !== m_rd(ta[fin])) begin
                            n_fail++; $display("FAIL rand_rdata it=%0d owner_dbg=%0d got=%h want=%h", it, own[fin],
                                               own[fin] ? bus.o_dbg_rdata : bus.o_cpu_rdata, m_rd(ta[fin]));
                        end
                    end
                end
                if (bus.o_dbg_gnt) bus.i_dbg_req = 0;
                if (lag == 0) begin bus.i_MIO_EN = 0; lag = -1; end
                else if (lag > 0) lag--;
                if (bus.o_Ready_Bit) lag = $urandom_range(0, 3);
            end
            n_chk++;
            if (done != n) begin
                n_fail++; $display("FAIL rand_timeout it=%0d completed=%0d want=%0d", it, done, n);
            end
            drive_idle();
            tick();
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_wait1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
